// File: rtl/usb_ps2_keyfifo.sv
// Circular-buffer scancode FIFO between the MCU/USB-PS2 bridge and the CPU keyboard port.
// Incoming scancodes are staged for one cycle and then committed; overflow leaves a one-shot marker.
module usb_ps2_keyfifo #(
    parameter int              DATA_W     = 8,
    parameter int              DEPTH      = 16,
    parameter logic [DATA_W-1:0] OVF_CODE = 8'hFF,
    parameter bit              UPD_TOGGLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          kb_scancode,
    input  logic                       kb_upd,
    input  logic                       keybuf_rd,
    input  logic                       keybuf_flush,
    output logic [DATA_W-1:0]          keybuf_data,
    output logic                       keybuf_empty,
    output logic                       keybuf_full,
    output logic [$clog2(DEPTH+1)-1:0] keybuf_level,
    output logic                       keybuf_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    logic              prev_upd_q, prev_upd_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] stage_data_q, stage_data_d;
    logic              push_req_q, push_req_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic upd_evt;
    logic pop_clr, pop_deq, push_ok, push_drop;

    always_comb begin
        // armed_q masks the first post-reset cycle so a static kb_upd level is not seen as a toggle
        if (UPD_TOGGLE) begin
            upd_evt = armed_q && (kb_upd != prev_upd_q);
        end else begin
            upd_evt = kb_upd;
        end
        prev_upd_d = kb_upd;
        armed_d    = 1'b1;

        pop_clr   = keybuf_rd && ovf_q;
        pop_deq   = keybuf_rd && !ovf_q && (level_q != '0);
        push_ok   = push_req_q && ((level_q != LVL_MAX) || pop_deq);
        push_drop = push_req_q && !push_ok;

        stage_data_d = upd_evt ? kb_scancode : stage_data_q;
        push_req_d   = upd_evt;

        mem_d = mem_q;
        if (push_ok && !keybuf_flush) begin
            mem_d[wr_ptr_q] = stage_data_q;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_deq);

        level_d = level_q;
        if (push_ok && !pop_deq) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop_deq) begin
            level_d = level_q - LVL_W'(1);
        end

        // a drop during a marker-clearing pop re-arms the marker
        ovf_d = ovf_q;
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (pop_clr) begin
            ovf_d = 1'b0;
        end

        if (keybuf_flush) begin
            stage_data_d = '0;
            push_req_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_upd_q   <= 1'b0;
            armed_q      <= 1'b0;
            stage_data_q <= '0;
            push_req_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            prev_upd_q   <= prev_upd_d;
            armed_q      <= armed_d;
            stage_data_q <= stage_data_d;
            push_req_q   <= push_req_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
        end
    end

    // storage is qualified by level, so it needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        if (ovf_q) begin
            keybuf_data = OVF_CODE;
        end else if (level_q != '0) begin
            keybuf_data = mem_q[rd_ptr_q];
        end else begin
            keybuf_data = '0;
        end
    end

    assign keybuf_empty = (level_q == '0) && !ovf_q;
    assign keybuf_full  = (level_q == LVL_MAX);
    assign keybuf_level = level_q;
    assign keybuf_ovf   = ovf_q;

endmodule
